rgb2yuv: RTL and testbench

RGB2YUV -- requirements
Module: rgb2yuv

---
 rtl/rgb2yuv.sv | 260 ++++++++++++++++++++++++++
 tb/tb_rgb2yuv.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rgb2yuv.sv
// rgb2yuv: four-stage pipelined RGB to full-range BT.601 YCbCr converter.
// Stage 1 forms the coefficient products with shift-add, stage 2 sums them,
// stage 3 clamps and truncates to 8 bits, stage 4 registers the outputs.
// Syncs and data enable follow through a matching 4-deep shift register.
// Optional feature macro: RGB2YUV_422_EN adds a 4:2:2 chroma multiplexer
// (c_out/c_sel) with co-sited Cr decimation; without it c_out/c_sel are 0.
module rgb2yuv (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] r_in,
   input  logic [7:0] g_in,
   input  logic [7:0] b_in,
   input  logic       vs_in,
   input  logic       hs_in,
   input  logic       de_in,
   output logic [7:0] y_out,
   output logic [7:0] u_out,
   output logic [7:0] v_out,
   output logic [7:0] c_out,
   output logic       c_sel,
   output logic       vs_out,
   output logic       hs_out,
   output logic       de_out
);

   // Unsigned products of one 8-bit component and one 8-bit coefficient
   typedef struct packed {
      logic [15:0] yr;
      logic [15:0] yg;
      logic [15:0] yb;
      logic [15:0] ur;
      logic [15:0] ug;
      logic [15:0] ub;
      logic [15:0] vr;
      logic [15:0] vg;
      logic [15:0] vb;
   } prod_t;

   // x*77 = x*(64+8+4+1)
   function automatic logic [15:0] mul77(input logic [7:0] x);
      logic [15:0] w;
      w = {8'd0, x};
      return (w << 6) + (w << 3) + (w << 2) + w;
   endfunction

   // x*150 = x*(128+16+4+2)
   function automatic logic [15:0] mul150(input logic [7:0] x);
      logic [15:0] w;
      w = {8'd0, x};
      return (w << 7) + (w << 4) + (w << 2) + (w << 1);
   endfunction

   // x*29 = x*(16+8+4+1)
   function automatic logic [15:0] mul29(input logic [7:0] x);
      logic [15:0] w;
      w = {8'd0, x};
      return (w << 4) + (w << 3) + (w << 2) + w;
   endfunction

   // x*43 = x*(32+8+2+1)
   function automatic logic [15:0] mul43(input logic [7:0] x);
      logic [15:0] w;
      w = {8'd0, x};
      return (w << 5) + (w << 3) + (w << 1) + w;
   endfunction

   // x*85 = x*(64+16+4+1)
   function automatic logic [15:0] mul85(input logic [7:0] x);
      logic [15:0] w;
      w = {8'd0, x};
      return (w << 6) + (w << 4) + (w << 2) + w;
   endfunction

   // x*128 = x<<7
   function automatic logic [15:0] mul128(input logic [7:0] x);
      logic [15:0] w;
      w = {8'd0, x};
      return (w << 7);
   endfunction

   // x*107 = x*(64+32+8+2+1)
   function automatic logic [15:0] mul107(input logic [7:0] x);
      logic [15:0] w;
      w = {8'd0, x};
      return (w << 6) + (w << 5) + (w << 3) + (w << 1) + w;
   endfunction

   // x*21 = x*(16+4+1)
   function automatic logic [15:0] mul21(input logic [7:0] x);
      logic [15:0] w;
      w = {8'd0, x};
      return (w << 4) + (w << 2) + w;
   endfunction

   // Zero-extend an unsigned product into the signed 19-bit sum domain
   function automatic logic signed [18:0] ext19(input logic [15:0] p);
      return $signed({3'b000, p});
   endfunction

   // Take bits [15:8] of a sum, saturating below 0 and at 65536 or above
   function automatic logic [7:0] clamp8(input logic signed [18:0] s);
      logic [7:0] res;
      if (s < 19'sd0) begin
         res = 8'd0;
      end else if (s > 19'sd65535) begin
         res = 8'd255;
      end else begin
         res = s[15:8];
      end
      return res;
   endfunction

   prod_t                prod_d, prod_q;
   logic signed [18:0]   y_sum_d, y_sum_q;
   logic signed [18:0]   u_sum_d, u_sum_q;
   logic signed [18:0]   v_sum_d, v_sum_q;
   logic [7:0]           y3_d, y3_q, u3_d, u3_q, v3_d, v3_q;
   logic [7:0]           y_out_d, y_out_q, u_out_d, u_out_q, v_out_d, v_out_q;
   // sync_q[k] holds {vs,hs,de} after k+1 clocks
   logic [3:0][2:0]      sync_d, sync_q;

   // Datapath next-state: products, sums, clamp, output stage, sync shift
   always_comb begin
      prod_d.yr = mul77(r_in);
      prod_d.yg = mul150(g_in);
      prod_d.yb = mul29(b_in);
      prod_d.ur = mul43(r_in);
      prod_d.ug = mul85(g_in);
      prod_d.ub = mul128(b_in);
      prod_d.vr = mul128(r_in);
      prod_d.vg = mul107(g_in);
      prod_d.vb = mul21(b_in);

      y_sum_d = ext19(prod_q.yr) + ext19(prod_q.yg) + ext19(prod_q.yb) + 19'sd128;
      u_sum_d = 19'sd32896 - ext19(prod_q.ur) - ext19(prod_q.ug) + ext19(prod_q.ub);
      v_sum_d = 19'sd32896 + ext19(prod_q.vr) - ext19(prod_q.vg) - ext19(prod_q.vb);

      y3_d = clamp8(y_sum_q);
      u3_d = clamp8(u_sum_q);
      v3_d = clamp8(v_sum_q);

      y_out_d = y3_q;
      u_out_d = u3_q;
      v_out_d = v3_q;

      sync_d[0]   = {vs_in, hs_in, de_in};
      sync_d[3:1] = sync_q[2:0];
   end

   // Datapath and sync pipeline registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q  <= '0;
         y_sum_q <= 19'sd0;
         u_sum_q <= 19'sd0;
         v_sum_q <= 19'sd0;
         y3_q    <= 8'd0;
         u3_q    <= 8'd0;
         v3_q    <= 8'd0;
         y_out_q <= 8'd0;
         u_out_q <= 8'd0;
         v_out_q <= 8'd0;
         sync_q  <= 12'd0;
      end else begin
         prod_q  <= prod_d;
         y_sum_q <= y_sum_d;
         u_sum_q <= u_sum_d;
         v_sum_q <= v_sum_d;
         y3_q    <= y3_d;
         u3_q    <= u3_d;
         v3_q    <= v3_d;
         y_out_q <= y_out_d;
         u_out_q <= u_out_d;
         v_out_q <= v_out_d;
         sync_q  <= sync_d;
      end
   end

   assign y_out  = y_out_q;
   assign u_out  = u_out_q;
   assign v_out  = v_out_q;
   assign vs_out = sync_q[3][2];
   assign hs_out = sync_q[3][1];
   assign de_out = sync_q[3][0];

`ifdef RGB2YUV_422_EN
   // phase_q is the phase the next stage-3 pixel will take if de is high
   typedef enum logic {
      PH_CB = 1'b0,
      PH_CR = 1'b1
   } phase_e;

   phase_e     phase_d, phase_q;
   logic [7:0] cr_hold_d, cr_hold_q;
   logic [7:0] c_out_d, c_out_q;
   logic       c_sel_d, c_sel_q;
   logic       de3_s;

   // de aligned with the stage-3 pixel data
   assign de3_s = sync_q[2][0];

   // Phase state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= PH_CB;
      end else begin
         phase_q <= phase_d;
      end
   end

   // Next phase: toggle while de is high, forced to CB in blanking
   always_comb begin
      phase_d = PH_CB;
      if (de3_s) begin
         case (phase_q)
            PH_CB:   phase_d = PH_CR;
            PH_CR:   phase_d = PH_CB;
            default: phase_d = PH_CB;
         endcase
      end else begin
         phase_d = PH_CB;
      end
   end

   // Chroma mux: Cb of even pixel (holding its Cr), then the held Cr
   always_comb begin
      c_sel_d   = 1'b0;
      c_out_d   = u3_q;
      cr_hold_d = cr_hold_q;
      if (de3_s && (phase_q == PH_CR)) begin
         c_sel_d = 1'b1;
         c_out_d = cr_hold_q;
      end else if (de3_s) begin
         cr_hold_d = v3_q;
      end else begin
         c_sel_d = 1'b0;
      end
   end

   // Held Cr and stage-4 chroma output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cr_hold_q <= 8'd0;
         c_out_q   <= 8'd0;
         c_sel_q   <= 1'b0;
      end else begin
         cr_hold_q <= cr_hold_d;
         c_out_q   <= c_out_d;
         c_sel_q   <= c_sel_d;
      end
   end

   assign c_out = c_out_q;
   assign c_sel = c_sel_q;
`else
   assign c_out = 8'd0;
   assign c_sel = 1'b0;
`endif

endmodule

// File: tb/tb_rgb2yuv.sv
// Directed testbench for rgb2yuv: reset state, colour conversion,
// 4:2:2 chroma phase (or constant-zero chroma in the default build),
// sync delay, and a mid-line reset pulse.
module tb_rgb2yuv;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] r_in = 8'd0, g_in = 8'd0, b_in = 8'd0;
   logic       vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
   logic [7:0] y_out, u_out, v_out, c_out;
   logic       c_sel, vs_out, hs_out, de_out;

   int n_vec = 0;
   int n_err = 0;

   // Colour table: 0 white, 1 black, 2 red, 3 blue, 4 green, 5 (100,150,200)
   localparam int NCOL = 6;
   localparam logic [7:0] COL_R [NCOL] = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd0,   8'd100};
   localparam logic [7:0] COL_G [NCOL] = '{8'd255, 8'd0, 8'd0,   8'd0, 8'd255, 8'd150};
   localparam logic [7:0] COL_B [NCOL] = '{8'd255, 8'd0, 8'd0,   8'd255, 8'd0, 8'd200};
   localparam logic [7:0] EXP_Y [NCOL] = '{8'd255, 8'd0,   8'd77,  8'd29,  8'd149, 8'd141};
   localparam logic [7:0] EXP_U [NCOL] = '{8'd128, 8'd128, 8'd85,  8'd255, 8'd43,  8'd161};
   localparam logic [7:0] EXP_V [NCOL] = '{8'd128, 8'd128, 8'd255, 8'd107, 8'd21,  8'd99};

   // Line of 5, blanking of 3, start of next line
   localparam int NLINE = 10;
   localparam int LINE_COL [NLINE] = '{3, 2, 4, 0, 3, 1, 1, 1, 2, 4};
   localparam logic LINE_DE [NLINE] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   localparam logic [7:0] LINE_COUT [NLINE] =
      '{8'd255, 8'd107, 8'd43, 8'd21, 8'd255, 8'd128, 8'd128, 8'd128, 8'd85, 8'd255};
   localparam logic LINE_CSEL [NLINE] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   // Sync pattern {vs,hs,de}
   localparam int NSYNC = 16;
   localparam logic [2:0] SYNC_PAT [NSYNC] = '{3'b101, 3'b010, 3'b111, 3'b000, 3'b001, 3'b110,
      3'b011, 3'b100, 3'b010, 3'b101, 3'b111, 3'b001, 3'b000, 3'b110, 3'b100, 3'b011};

   rgb2yuv dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .r_in   (r_in),
      .g_in   (g_in),
      .b_in   (b_in),
      .vs_in  (vs_in),
      .hs_in  (hs_in),
      .de_in  (de_in),
      .y_out  (y_out),
      .u_out  (u_out),
      .v_out  (v_out),
      .c_out  (c_out),
      .c_sel  (c_sel),
      .vs_out (vs_out),
      .hs_out (hs_out),
      .de_out (de_out)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int c, input logic de, input logic vs, input logic hs);
      r_in  = COL_R[c];
      g_in  = COL_G[c];
      b_in  = COL_B[c];
      de_in = de;
      vs_in = vs;
      hs_in = hs;
   endtask

   task automatic idle(input int n);
      drive(1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(0, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) step();
      n_vec++;
      if ({y_out, u_out, v_out, c_out, c_sel, vs_out, hs_out, de_out} !== 36'd0) begin
         n_err++;
         $display("FAIL reset_state: got %h expected 0",
                  {y_out, u_out, v_out, c_out, c_sel, vs_out, hs_out, de_out});
      end
      rst_n = 1'b1;
      idle(4);
   endtask

   task automatic test_colors();
      for (int i = 0; i < NCOL + 3; i++) begin
         if (i < NCOL) drive(i, 1'b1, 1'b0, 1'b0);
         else drive(1, 1'b0, 1'b0, 1'b0);
         step();
         if (i >= 3) begin
            n_vec++;
            if (y_out !== EXP_Y[i-3]) begin
               n_err++;
               $display("FAIL color%0d_y: got %0d expected %0d", i - 3, y_out, EXP_Y[i-3]);
            end
            n_vec++;
            if (u_out !== EXP_U[i-3]) begin
               n_err++;
               $display("FAIL color%0d_u: got %0d expected %0d", i - 3, u_out, EXP_U[i-3]);
            end
            n_vec++;
            if (v_out !== EXP_V[i-3]) begin
               n_err++;
               $display("FAIL color%0d_v: got %0d expected %0d", i - 3, v_out, EXP_V[i-3]);
            end
         end
      end
      idle(4);
   endtask

   task automatic test_chroma();
      idle(4);
      for (int i = 0; i < NLINE + 3; i++) begin
         if (i < NLINE) drive(LINE_COL[i], LINE_DE[i], 1'b0, 1'b0);
         else drive(1, 1'b0, 1'b0, 1'b0);
         step();
         if (i >= 3) begin
`ifdef RGB2YUV_422_EN
            n_vec++;
            if (c_out !== LINE_COUT[i-3]) begin
               n_err++;
               $display("FAIL chroma%0d_cout: got %0d expected %0d", i - 3, c_out, LINE_COUT[i-3]);
            end
            n_vec++;
            if (c_sel !== LINE_CSEL[i-3]) begin
               n_err++;
               $display("FAIL chroma%0d_csel: got %0d expected %0d", i - 3, c_sel, LINE_CSEL[i-3]);
            end
`else
            n_vec++;
            if ({c_out, c_sel} !== 9'd0) begin
               n_err++;
               $display("FAIL chroma%0d_off: got %0d/%0d expected 0/0", i - 3, c_out, c_sel);
            end
`endif
            n_vec++;
            if (de_out !== LINE_DE[i-3]) begin
               n_err++;
               $display("FAIL chroma%0d_de: got %0d expected %0d", i - 3, de_out, LINE_DE[i-3]);
            end
         end
      end
      idle(4);
   endtask

   task automatic test_sync();
      for (int i = 0; i < NSYNC + 3; i++) begin
         if (i < NSYNC) drive(5, SYNC_PAT[i][0], SYNC_PAT[i][2], SYNC_PAT[i][1]);
         else drive(1, 1'b0, 1'b0, 1'b0);
         step();
         if (i >= 3) begin
            n_vec++;
            if ({vs_out, hs_out, de_out} !== SYNC_PAT[i-3]) begin
               n_err++;
               $display("FAIL sync%0d: got %b expected %b", i - 3, {vs_out, hs_out, de_out}, SYNC_PAT[i-3]);
            end
         end
      end
      idle(4);
   endtask

   task automatic test_reset_midline();
      logic [7:0] exp_y [5];
      logic [7:0] exp_u [5];
      logic       exp_de [5];
      logic [7:0] exp_c [5];
      logic       exp_cs [5];
      exp_y  = '{8'd0, 8'd0, 8'd0, 8'd255, 8'd255};
      exp_u  = '{8'd0, 8'd0, 8'd128, 8'd128, 8'd128};
      exp_de = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      exp_c  = '{8'd0, 8'd0, 8'd128, 8'd128, 8'd128};
      exp_cs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      drive(0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) step();
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({y_out, u_out, v_out, c_out, c_sel, vs_out, hs_out, de_out} !== 36'd0) begin
         n_err++;
         $display("FAIL midreset_async: got %h expected 0",
                  {y_out, u_out, v_out, c_out, c_sel, vs_out, hs_out, de_out});
      end
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         n_vec++;
         if (y_out !== exp_y[k]) begin
            n_err++;
            $display("FAIL midreset%0d_y: got %0d expected %0d", k + 1, y_out, exp_y[k]);
         end
         n_vec++;
         if (u_out !== exp_u[k]) begin
            n_err++;
            $display("FAIL midreset%0d_u: got %0d expected %0d", k + 1, u_out, exp_u[k]);
         end
         n_vec++;
         if (de_out !== exp_de[k]) begin
            n_err++;
            $display("FAIL midreset%0d_de: got %0d expected %0d", k + 1, de_out, exp_de[k]);
         end
`ifdef RGB2YUV_422_EN
         n_vec++;
         if ({c_out, c_sel} !== {exp_c[k], exp_cs[k]}) begin
            n_err++;
            $display("FAIL midreset%0d_chroma: got %0d/%0d expected %0d/%0d",
                     k + 1, c_out, c_sel, exp_c[k], exp_cs[k]);
         end
`else
         n_vec++;
         if ({c_out, c_sel} !== 9'd0) begin
            n_err++;
            $display("FAIL midreset%0d_chroma: got %0d/%0d expected 0/0 (%0d/%0d unused)",
                     k + 1, c_out, c_sel, exp_c[k], exp_cs[k]);
         end
`endif
      end
      idle(4);
   endtask

   initial begin
      test_reset();
      test_colors();
      test_chroma();
      test_sync();
      test_reset_midline();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
